register_arbiter: RTL and testbench

Shares a bank of `register_unit` instances between several move-bus requesters. Each cycle in idle it picks one pending request, drives exactly one register's select/write-strobe for one cycle, and returns the register's prior contents to the winner. It sits between the transport ports and the register bank, and is the only driver of the bank's `sel_i`, `wstrb_i` and `data_i` inputs.

---
 rtl/regarb_pkg.sv | 13 +
 rtl/regarb_picker.sv | 49 ++++
 rtl/register_arbiter.sv | 178 +++++++++++++++++
 tb/tb_register_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
// rtl/regarb_pkg.sv - shared types and constants for the register arbiter
package regarb_pkg;

  // Arbiter FSM: pick in IDLE, drive the bank in ACCESS, capture read data in RESP
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int DATA_W = 32;

endpackage

// File: rtl/regarb_picker.sv
// rtl/regarb_picker.sv - combinational winner selection; REGARB_RR_EN selects round-robin over fixed priority
module regarb_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               any_o
);

  logic found;

  assign any_o = |req_i;

`ifdef REGARB_RR_EN
  // Round-robin: scan from the requester after the last winner, wrapping once
  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] &&
            ((int'(ptr_i) + off == i) || (int'(ptr_i) + off == i + NUM_REQ))) begin
          win_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  // The pointer is meaningless under fixed priority
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Fixed priority: lowest pending index wins
  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        win_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/register_arbiter.sv
// rtl/register_arbiter.sv - shares a register bank between requesters, one access per 3 cycles; REGARB_RR_EN enables round-robin
module register_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_REGS-1:0]        reg_sel_o,
  output logic                       reg_wstrb_o,
  output logic [DATA_W-1:0]          reg_data_o,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  win_q, win_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REGS-1:0] sel_q, sel_d;
  logic                wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [NUM_REQ-1:0]  win;
  logic                any;
  logic [PTR_W-1:0]    ptr;
  logic [ADDR_W-1:0]   pick_addr;
  logic                pick_we;
  logic [DATA_W-1:0]   pick_wdata;
  logic [NUM_REGS-1:0] sel_dec;
  logic [DATA_W-1:0]   rd_word;

`ifdef REGARB_RR_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  // Pointer follows the winner of every grant
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (win[k]) ptr_d = PTR_W'(k);
      end
    end
  end

  // Reset leaves the pointer on the last requester so requester 0 wins first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= PTR_W'(NUM_REQ - 1);
    else       ptr_q <= ptr_d;
  end
`else
  assign ptr = PTR_W'(NUM_REQ - 1);
`endif

  regarb_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i (req_i),
    .ptr_i (ptr),
    .win_o (win),
    .any_o (any)
  );

  // Steer the winning requester's command onto the internal pick bus
  always_comb begin
    pick_addr  = '0;
    pick_we    = 1'b0;
    pick_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        pick_addr  = addr_i[k*ADDR_W +: ADDR_W];
        pick_we    = we_i[k];
        pick_wdata = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // One-hot decode; out-of-range addresses decode to no select at all
  always_comb begin
    sel_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) sel_dec[r] = (pick_addr == ADDR_W'(r));
  end

  // Read-back mux of the latched address; out-of-range reads return zero
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (addr_q == ADDR_W'(r)) rd_word = reg_data_i[r*DATA_W +: DATA_W];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      addr_q   <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      wstrb_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      sel_q    <= sel_d;
      wstrb_q  <= wstrb_d;
      data_q   <= data_d;
    end
  end

  // Next state: a granted access always walks ACCESS then RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output next values: bank strobes for the ACCESS cycle, response for the cycle after RESP
  always_comb begin
    win_d    = win_q;
    addr_d   = addr_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    sel_d    = '0;
    wstrb_d  = 1'b0;
    data_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          win_d   = win;
          addr_d  = pick_addr;
          gnt_d   = win;
          sel_d   = sel_dec;
          wstrb_d = pick_we & (|sel_dec);
          data_d  = pick_wdata;
        end
      end
      ST_RESP: begin
        rvalid_d = win_q;
        rdata_d  = rd_word;
      end
      default: ;
    endcase
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign reg_sel_o   = sel_q;
  assign reg_wstrb_o = wstrb_q;
  assign reg_data_o  = data_q;

endmodule

// File: tb/tb_register_arbiter.sv
// tb/tb_register_arbiter.sv - directed self-checking bench for register_arbiter with a behavioural register bank
module tb_register_arbiter;

  localparam int NREQ  = 2;
  localparam int NREGS = 12;
  localparam int AW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*32-1:0]    wdata;
  logic [NREQ-1:0]       gnt, rvalid;
  logic [31:0]           rdata;
  logic [NREGS-1:0]      sel;
  logic                  wstrb;
  logic [31:0]           wbus;
  logic [NREGS*32-1:0]   bank_out;

  logic [31:0] bank_r [NREGS] = '{default: '0};
  logic [31:0] bank_q [NREGS] = '{default: '0};

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_gnt [4];

  always #5 clk = ~clk;

  register_arbiter #(
    .NUM_REQ  (NREQ),
    .NUM_REGS (NREGS),
    .ADDR_W   (AW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .reg_sel_o   (sel),
    .reg_wstrb_o (wstrb),
    .reg_data_o  (wbus),
    .reg_data_i  (bank_out)
  );

  // Bank model: on select, data_o takes the old contents, then the write lands
  always @(posedge clk) begin
    for (int k = 0; k < NREGS; k++) begin
      if (sel[k]) begin
        bank_q[k] <= bank_r[k];
        if (wstrb) bank_r[k] <= wbus;
      end
    end
  end

  always_comb begin
    bank_out = '0;
    for (int k = 0; k < NREGS; k++) bank_out[k*32 +: 32] = bank_q[k];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    tick(); tick();
    check("rst_gnt",    32'(gnt),    32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata",  rdata,       32'h0);
    check("rst_sel",    32'(sel),    32'h0);
    check("rst_wstrb",  32'(wstrb),  32'h0);
    check("rst_wbus",   wbus,        32'h0);
    rst = 1'b0;

    // Write 0xDEADBEEF to reg 3 from requester 0
    req = 2'b01; we = 2'b01; addr[3:0] = 4'd3; wdata[31:0] = 32'hDEADBEEF;
    tick();
    check("wr_gnt",   32'(gnt),   32'h1);
    check("wr_sel",   32'(sel),   32'h008);
    check("wr_wstrb", 32'(wstrb), 32'h1);
    check("wr_wbus",  wbus,       32'hDEADBEEF);
    req = '0;
    tick();
    check("wr_resp_gnt", 32'(gnt), 32'h0);
    check("wr_resp_sel", 32'(sel), 32'h0);
    tick();
    check("wr_rvalid", 32'(rvalid), 32'h1);
    check("wr_rdata",  rdata,       32'h0);

    // Read reg 3 back
    req = 2'b01; we = 2'b00;
    tick();
    check("rd_gnt",   32'(gnt),   32'h1);
    check("rd_wstrb", 32'(wstrb), 32'h0);
    req = '0;
    tick(); tick();
    check("rd_rvalid", 32'(rvalid), 32'h1);
    check("rd_rdata",  rdata,       32'hDEADBEEF);
    tick();
    check("rd_rvalid_drop", 32'(rvalid), 32'h0);
    check("rd_rdata_hold",  rdata,       32'hDEADBEEF);

    // Out-of-range write to addr 13 with NUM_REGS = 12
    req = 2'b01; we = 2'b01; addr[3:0] = 4'd13; wdata[31:0] = 32'h12345678;
    tick();
    check("oor_gnt",   32'(gnt),   32'h1);
    check("oor_sel",   32'(sel),   32'h0);
    check("oor_wstrb", 32'(wstrb), 32'h0);
    req = '0;
    tick(); tick();
    check("oor_rvalid", 32'(rvalid), 32'h1);
    check("oor_rdata",  rdata,       32'h0);

    // Reset asserted between edges during a write's ACCESS cycle
    req = 2'b01; we = 2'b01; addr[3:0] = 4'd4; wdata[31:0] = 32'h0000CAFE;
    tick();
    check("racc_gnt_before", 32'(gnt), 32'h1);
    req = '0;
    #2 rst = 1'b1;
    #1;
    check("racc_gnt",   32'(gnt),   32'h0);
    check("racc_sel",   32'(sel),   32'h0);
    check("racc_wstrb", 32'(wstrb), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("racc_no_rvalid", 32'(rvalid), 32'h0);
    end

    // Contention: both requesters hold reads of reg 1 and reg 2
`ifdef REGARB_RR_EN
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
`else
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`endif
    req = 2'b11; we = 2'b00; addr = {4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_gnt", 32'(gnt), 32'(exp_gnt[i]));
      tick(); tick();
      check("cont_rvalid", 32'(rvalid), 32'(exp_gnt[i]));
    end
    req = '0;
    tick();

    // Back-to-back writes 1..4 to reg 5 from requester 1, one grant every 3 cycles
    req = 2'b10; we = 2'b10; addr[7:4] = 4'd5; wdata[63:32] = 32'd1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("b2b_gnt",  32'(gnt), 32'h2);
      check("b2b_sel",  32'(sel), 32'h020);
      check("b2b_wbus", wbus,     32'(i));
      wdata[63:32] = 32'(i + 1);
      tick();
      check("b2b_resp_gnt", 32'(gnt), 32'h0);
      tick();
      check("b2b_rvalid", 32'(rvalid), 32'h2);
      check("b2b_prior",  rdata,       32'(i - 1));
    end
    we = 2'b00;
    tick();
    check("b2b_rd_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick(); tick();
    check("b2b_rd_rvalid", 32'(rvalid), 32'h2);
    check("b2b_rd_rdata",  rdata,       32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
